// File: rtl/dt_skeleton.sv
// Ridge (medial-axis) extractor for a distance map: scans the distance RAM in raster order
// and packs one ridge bit per pixel, 16 pixels per word, into the skeleton RAM.
module dt_skeleton #(
  parameter int IMG_W = 128,
  parameter int IMG_H = 128
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        res_rd,
  output logic [13:0] res_addr,
  input  logic [7:0]  res_di,
  output logic        sk_wr,
  output logic [9:0]  sk_addr,
  output logic [15:0] sk_do,
  output logic [7:0]  max_dist,
  output logic [13:0] sk_count,
  output logic        done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [13:0]   ROW_STEP = 14'(IMG_W);

  typedef enum logic [3:0] {
    IDLE, RD_C, CAP_C, RD_N, RD_S, RD_W, RD_E, DECIDE, WR, FIN
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] col_q;
  logic [RW-1:0] row_q;
  logic [13:0]   addr_q;     // row*IMG_W+col, advanced alongside col_q
  logic [9:0]    waddr_q;    // row*(IMG_W/16)+col/16, advanced on every word write
  logic [7:0]    centre_q;
  logic          cand_q;     // interior and nonzero: neighbour reads were issued
  logic          ge_q;       // centre >= every neighbour compared so far
  logic [15:0]   shift_q;
  logic [7:0]    max_q;
  logic [13:0]   count_q;

  logic interior, last_col, last_word, ridge_bit;

  assign interior  = (row_q != '0) && (row_q != ROW_LAST) &&
                     (col_q != '0) && (col_q != COL_LAST);
  assign last_col  = (col_q == COL_LAST);
  assign last_word = last_col && (row_q == ROW_LAST);
  // In DECIDE res_di carries the east neighbour read issued in RD_E.
  assign ridge_bit = cand_q && ge_q && (centre_q >= res_di);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_d  = state_q;
    res_rd   = 1'b0;
    res_addr = '0;
    sk_wr    = 1'b0;
    sk_addr  = '0;
    sk_do    = '0;
    unique case (state_q)
      IDLE, FIN: if (start) state_d = RD_C;
      RD_C: begin
        res_rd   = 1'b1;
        res_addr = addr_q;
        state_d  = CAP_C;
      end
      CAP_C: state_d = (interior && res_di != 8'd0) ? RD_N : DECIDE;
      RD_N: begin
        res_rd   = 1'b1;
        res_addr = addr_q - ROW_STEP;
        state_d  = RD_S;
      end
      RD_S: begin
        res_rd   = 1'b1;
        res_addr = addr_q + ROW_STEP;
        state_d  = RD_W;
      end
      RD_W: begin
        res_rd   = 1'b1;
        res_addr = addr_q - 14'd1;
        state_d  = RD_E;
      end
      RD_E: begin
        res_rd   = 1'b1;
        res_addr = addr_q + 14'd1;
        state_d  = DECIDE;
      end
      DECIDE: state_d = (col_q[3:0] == 4'hF) ? WR : RD_C;
      WR: begin
        sk_wr   = 1'b1;
        sk_addr = waddr_q;
        sk_do   = shift_q;
        state_d = last_word ? FIN : RD_C;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous; all state, including scratch registers, uses non-blocking updates.
    if (!reset) begin
      state_q  <= IDLE;
      col_q    <= '0;
      row_q    <= '0;
      addr_q   <= '0;
      waddr_q  <= '0;
      centre_q <= '0;
      cand_q   <= 1'b0;
      ge_q     <= 1'b0;
      shift_q  <= '0;
      max_q    <= '0;
      count_q  <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE, FIN: begin
          if (start) begin
            col_q   <= '0;
            row_q   <= '0;
            addr_q  <= '0;
            waddr_q <= '0;
            shift_q <= '0;
            max_q   <= '0;
            count_q <= '0;
          end
        end
        CAP_C: begin
          centre_q <= res_di;
          if (res_di > max_q) max_q <= res_di;
          cand_q <= interior && (res_di != 8'd0);
          ge_q   <= 1'b1;
        end
        RD_S, RD_W, RD_E: ge_q <= ge_q && (centre_q >= res_di);
        DECIDE: begin
          shift_q <= {shift_q[14:0], ridge_bit};
          if (ridge_bit && count_q != '1) count_q <= count_q + 14'd1;
          if (col_q[3:0] != 4'hF) begin
            col_q  <= col_q + 1'b1;
            addr_q <= addr_q + 14'd1;
          end
        end
        WR: begin
          waddr_q <= waddr_q + 10'd1;
          addr_q  <= addr_q + 14'd1;
          if (last_col) begin
            col_q <= '0;
            row_q <= row_q + 1'b1;
          end else begin
            col_q <= col_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign max_dist = max_q;
  assign sk_count = count_q;
  assign done     = (state_q == FIN);

endmodule

// File: tb/tb_dt_skeleton.sv
// Directed bench for dt_skeleton on a reduced 48x32 image with behavioural distance and skeleton RAMs.
module tb_dt_skeleton;

  localparam int W          = 48;
  localparam int H          = 32;
  localparam int NPIX       = W * H;
  localparam int WORDS      = NPIX / 16;
  localparam int SCAN_LIMIT = 20000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        res_rd;
  logic [13:0] res_addr;
  logic [7:0]  res_di = 8'd0;
  logic        sk_wr;
  logic [9:0]  sk_addr;
  logic [15:0] sk_do;
  logic [7:0]  max_dist;
  logic [13:0] sk_count;
  logic        done;

  logic [7:0]  res_mem [NPIX];
  logic [15:0] sk_mem  [WORDS];
  int          sk_seen [WORDS];
  int          wr_cnt = 0;
  int          scan_id = 0;

  logic [15:0] exp_words [WORDS];
  int          exp_count, exp_max, exp_cand;

  int checks = 0;
  int errors = 0;

  dt_skeleton #(.IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .reset(reset), .start(start),
    .res_rd(res_rd), .res_addr(res_addr), .res_di(res_di),
    .sk_wr(sk_wr), .sk_addr(sk_addr), .sk_do(sk_do),
    .max_dist(max_dist), .sk_count(sk_count), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (res_rd && int'(res_addr) < NPIX) res_di <= res_mem[res_addr];
  end

  always @(posedge clk) begin
    if (sk_wr) begin
      wr_cnt <= wr_cnt + 1;
      if (int'(sk_addr) < WORDS) begin
        sk_mem[sk_addr]  <= sk_do;
        sk_seen[sk_addr] <= scan_id;
      end
    end
  end

  task automatic clear_map();
    for (int i = 0; i < NPIX; i++) res_mem[i] = 8'd0;
  endtask

  task automatic put(input int r, input int c, input int v);
    res_mem[r * W + c] = 8'(v);
  endtask

  // Reference ridge rule evaluated directly on the image.
  task automatic compute_model();
    exp_count = 0;
    exp_max   = 0;
    exp_cand  = 0;
    for (int i = 0; i < WORDS; i++) exp_words[i] = 16'h0000;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        int v;
        bit b;
        v = int'(res_mem[r * W + c]);
        b = 1'b0;
        if (v > exp_max) exp_max = v;
        if (r > 0 && r < H - 1 && c > 0 && c < W - 1 && v != 0) begin
          exp_cand++;
          b = (v >= int'(res_mem[(r - 1) * W + c])) && (v >= int'(res_mem[(r + 1) * W + c])) &&
              (v >= int'(res_mem[r * W + c - 1]))   && (v >= int'(res_mem[r * W + c + 1]));
        end
        if (b) begin
          exp_count++;
          exp_words[r * (W / 16) + c / 16][15 - (c % 16)] = 1'b1;
        end
      end
    end
  endtask

  // Runs one scan from a start pulse; optional second start at cycle restart_at (0 = none).
  task automatic run_scan(input string name, input int restart_at);
    int cyc, w0, exp_cyc, bad, first_bad;
    compute_model();
    scan_id = scan_id + 1;
    w0 = wr_cnt;
    exp_cyc = 3 * NPIX + 4 * exp_cand + WORDS + 1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; cyc = 1;
    while (done !== 1'b1 && cyc < SCAN_LIMIT) begin
      start = (restart_at != 0 && cyc == restart_at);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;

    checks++;
    if (done !== 1'b1 || cyc !== exp_cyc) begin
      errors++;
      $display("FAIL %s latency: done=%b after %0d cycles, expected %0d", name, done, cyc, exp_cyc);
    end
    checks++;
    if (wr_cnt - w0 !== WORDS) begin
      errors++;
      $display("FAIL %s write count: got %0d, expected %0d", name, wr_cnt - w0, WORDS);
    end
    bad = 0;
    first_bad = -1;
    for (int i = 0; i < WORDS; i++) begin
      if (sk_seen[i] != scan_id || sk_mem[i] !== exp_words[i]) begin
        bad++;
        if (first_bad < 0) first_bad = i;
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s skeleton map: %0d bad words, first %0d got %h expected %h", name, bad,
               first_bad, sk_mem[first_bad], exp_words[first_bad]);
    end
    checks++;
    if (sk_count !== 14'(exp_count)) begin
      errors++;
      $display("FAIL %s sk_count: got %0d, expected %0d", name, sk_count, exp_count);
    end
    checks++;
    if (max_dist !== 8'(exp_max)) begin
      errors++;
      $display("FAIL %s max_dist: got %0d, expected %0d", name, max_dist, exp_max);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({done, max_dist, sk_count} !== 23'd0) begin
      errors++;
      $display("FAIL reset status: done=%b max=%0d count=%0d, expected all 0", done, max_dist, sk_count);
    end
    checks++;
    if ({res_rd, res_addr, sk_wr, sk_addr, sk_do} !== 42'd0) begin
      errors++;
      $display("FAIL reset ram ports: rd=%b addr=%0d wr=%b waddr=%0d do=%h, expected 0",
               res_rd, res_addr, sk_wr, sk_addr, sk_do);
    end
    reset = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (done !== 1'b0 || res_rd !== 1'b0 || sk_wr !== 1'b0) begin
      errors++;
      $display("FAIL idle without start: done=%b rd=%b wr=%b, expected 0 0 0", done, res_rd, sk_wr);
    end
  endtask

  task automatic test_zero_map();
    clear_map();
    run_scan("zero map", 0);
    repeat (5) @(negedge clk);
    checks++;
    if (done !== 1'b1 || sk_wr !== 1'b0 || res_rd !== 1'b0) begin
      errors++;
      $display("FAIL zero map done hold: done=%b wr=%b rd=%b, expected 1 0 0", done, sk_wr, res_rd);
    end
  endtask

  task automatic test_single_pixel();
    clear_map();
    put(5, 20, 3);
    run_scan("single pixel", 0);
    checks++;
    if (sk_mem[16] !== 16'h0800) begin
      errors++;
      $display("FAIL single pixel word 16: got %h, expected 0800", sk_mem[16]);
    end
    checks++;
    if (sk_count !== 14'd1 || max_dist !== 8'd3) begin
      errors++;
      $display("FAIL single pixel totals: count=%0d max=%0d, expected 1 3", sk_count, max_dist);
    end
  endtask

  task automatic test_diamond();
    clear_map();
    for (int dr = -3; dr <= 3; dr++) begin
      for (int dc = -3; dc <= 3; dc++) begin
        int d;
        d = (dr < 0 ? -dr : dr) + (dc < 0 ? -dc : dc);
        if (d < 4) put(16 + dr, 32 + dc, 4 - d);
      end
    end
    run_scan("diamond", 0);
    checks++;
    if (sk_mem[50] !== 16'h8000 || sk_count !== 14'd1 || max_dist !== 8'd4) begin
      errors++;
      $display("FAIL diamond peak: word50=%h count=%0d max=%0d, expected 8000 1 4",
               sk_mem[50], sk_count, max_dist);
    end
  endtask

  task automatic plateau_map();
    clear_map();
    put(10, 30, 2); put(10, 31, 2); put(11, 30, 2); put(11, 31, 2);
    put(9, 30, 1);  put(9, 31, 1);  put(12, 30, 1); put(12, 31, 1);
    put(10, 29, 1); put(11, 29, 1); put(10, 32, 1); put(11, 32, 1);
  endtask

  task automatic test_plateau();
    plateau_map();
    run_scan("plateau", 0);
    checks++;
    if (sk_mem[31] !== 16'h0003 || sk_mem[34] !== 16'h0003) begin
      errors++;
      $display("FAIL plateau words: w31=%h w34=%h, expected 0003 0003", sk_mem[31], sk_mem[34]);
    end
    checks++;
    if (sk_count !== 14'd4) begin
      errors++;
      $display("FAIL plateau count: got %0d, expected 4", sk_count);
    end
  endtask

  task automatic test_border();
    clear_map();
    for (int c = 0; c < W; c++) put(0, c, 9);
    run_scan("border", 0);
    checks++;
    if ({sk_mem[0], sk_mem[1], sk_mem[2]} !== 48'd0 || max_dist !== 8'd9) begin
      errors++;
      $display("FAIL border row 0: words=%h %h %h max=%0d, expected 0 0 0 9",
               sk_mem[0], sk_mem[1], sk_mem[2], max_dist);
    end
  endtask

  task automatic test_reset_mid_scan();
    int n, w0, stray;
    plateau_map();
    put(5, 20, 3);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (!(res_rd === 1'b1 && res_addr === 14'd500) && n < SCAN_LIMIT) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= SCAN_LIMIT) begin
      errors++;
      $display("FAIL mid-scan wait: address 500 not read within %0d cycles", SCAN_LIMIT);
    end
    reset = 1'b0;
    w0 = wr_cnt;
    @(negedge clk);
    checks++;
    if ({res_rd, res_addr, sk_wr, sk_addr, sk_do, max_dist, sk_count, done} !== 65'd0) begin
      errors++;
      $display("FAIL mid-scan reset outputs: rd=%b addr=%0d wr=%b max=%0d count=%0d done=%b, expected 0",
               res_rd, res_addr, sk_wr, max_dist, sk_count, done);
    end
    stray = 0;
    repeat (4) begin
      @(negedge clk);
      if (sk_wr !== 1'b0 || res_rd !== 1'b0) stray++;
    end
    reset = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (sk_wr !== 1'b0 || res_rd !== 1'b0) stray++;
    end
    checks++;
    if (stray != 0 || wr_cnt != w0) begin
      errors++;
      $display("FAIL after abort: %0d active cycles, %0d writes, expected 0 0", stray, wr_cnt - w0);
    end
    run_scan("rescan after abort", 0);
  endtask

  task automatic test_start_while_busy();
    plateau_map();
    put(5, 20, 3);
    put(20, 40, 7);
    run_scan("start while busy", 300);
  endtask

  initial begin
    for (int i = 0; i < WORDS; i++) begin
      sk_seen[i] = 0;
      sk_mem[i]  = 16'h0000;
    end
    clear_map();
    test_reset();
    test_zero_map();
    test_single_pixel();
    test_diamond();
    test_plateau();
    test_border();
    test_reset_mid_scan();
    test_start_while_busy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
